// File: rtl/lsu_ctrl.sv
// Load-store sequencer: decodes core requests into data-memory (with sub-word
// read-modify-write) and IO req/ack accesses, returning one response per request.
module lsu_ctrl #(
  parameter int unsigned IO_TIMEOUT = 255
) (
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic        i_req_valid,
  output logic        o_req_ready,
  input  logic        i_req_we,
  input  logic [11:0] i_req_addr,
  input  logic [1:0]  i_req_size,
  input  logic        i_req_unsigned,
  input  logic [31:0] i_req_wdata,
  output logic        o_rsp_valid,
  output logic [31:0] o_rsp_rdata,
  output logic        o_rsp_err,
  output logic [5:0]  o_mem_addr,
  output logic        o_mem_wren,
  output logic [31:0] o_mem_wdata,
  input  logic [31:0] i_mem_rdata,
  output logic        o_io_req,
  output logic        o_io_wren,
  output logic [7:0]  o_io_addr,
  output logic [3:0]  o_io_bmask,
  output logic [31:0] o_io_wdata,
  input  logic        i_io_ack,
  input  logic [31:0] i_io_rdata
);

  localparam int unsigned DATA_W  = 32;
  localparam int unsigned LADDR_W = 8;
  localparam int unsigned CNT_W   = 8;
  localparam logic [CNT_W-1:0] TIMEOUT_CNT = CNT_W'(IO_TIMEOUT);

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;

  typedef enum logic [2:0] {
    S_IDLE,
    S_MEM_RD,
    S_MEM_DATA,
    S_MEM_WR,
    S_IO_REQ,
    S_RESP
  } state_t;

  state_t state_q, state_d;

  logic [LADDR_W-1:0] addr_q;
  logic [1:0]         size_q;
  logic               we_q;
  logic               uns_q;
  logic [DATA_W-1:0]  wbuf_q;
  logic [DATA_W-1:0]  rdata_q;
  logic               err_q;
  logic [CNT_W-1:0]   cnt_q;

  logic acc_err_c;
  logic acc_mem_c;
  logic timeout_c;
  logic [3:0] bmask_c;

  // Replicate right-aligned store data across every lane it may land in.
  function automatic logic [DATA_W-1:0] replicate(input logic [DATA_W-1:0] w,
                                                  input logic [1:0] size);
    logic [DATA_W-1:0] r;
    case (size)
      SZ_BYTE: r = {4{w[7:0]}};
      SZ_HALF: r = {2{w[15:0]}};
      default: r = w;
    endcase
    return r;
  endfunction

  function automatic logic [3:0] lane_mask(input logic [1:0] size,
                                           input logic [1:0] lane);
    logic [3:0] m;
    case (size)
      SZ_BYTE: m = 4'b0001 << lane;
      SZ_HALF: m = 4'b0011 << lane;
      SZ_WORD: m = 4'b1111;
      default: m = 4'b0000;
    endcase
    return m;
  endfunction

  function automatic logic [DATA_W-1:0] merge_lanes(input logic [DATA_W-1:0] new_w,
                                                    input logic [DATA_W-1:0] old_w,
                                                    input logic [3:0] mask);
    logic [DATA_W-1:0] r;
    for (int k = 0; k < 4; k++) begin
      r[8*k +: 8] = mask[k] ? new_w[8*k +: 8] : old_w[8*k +: 8];
    end
    return r;
  endfunction

  // Select the addressed lane and sign- or zero-extend it.
  function automatic logic [DATA_W-1:0] format_load(input logic [DATA_W-1:0] w,
                                                    input logic [1:0] lane,
                                                    input logic [1:0] size,
                                                    input logic uns);
    logic [DATA_W-1:0] sh;
    logic [DATA_W-1:0] r;
    sh = w >> {lane, 3'b000};
    case (size)
      SZ_BYTE: r = uns ? {24'h0, sh[7:0]}   : {{24{sh[7]}}, sh[7:0]};
      SZ_HALF: r = uns ? {16'h0, sh[15:0]}  : {{16{sh[15]}}, sh[15:0]};
      default: r = w;
    endcase
    return r;
  endfunction

  always_comb begin
    acc_mem_c = (i_req_addr[9:8] == 2'b01);
    acc_err_c = (i_req_size == 2'b11)
             || ((i_req_size == SZ_HALF) && i_req_addr[0])
             || ((i_req_size == SZ_WORD) && (i_req_addr[1:0] != 2'b00))
             || (i_req_addr[11:10] != 2'b00)
             || (i_req_addr[9:8] == 2'b00)
             || (i_req_addr[9:8] == 2'b11);
    timeout_c = (cnt_q == TIMEOUT_CNT);
    bmask_c   = lane_mask(size_q, addr_q[1:0]);
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) state_q <= S_IDLE;
    else         state_q <= state_d;
  end

  // Next state and output decode; every output is forced low during reset.
  always_comb begin
    state_d     = state_q;
    o_req_ready = 1'b0;
    o_rsp_valid = 1'b0;
    o_rsp_rdata = '0;
    o_rsp_err   = 1'b0;
    o_mem_addr  = '0;
    o_mem_wren  = 1'b0;
    o_mem_wdata = '0;
    o_io_req    = 1'b0;
    o_io_wren   = 1'b0;
    o_io_addr   = '0;
    o_io_bmask  = '0;
    o_io_wdata  = '0;
    case (state_q)
      S_IDLE: begin
        o_req_ready = 1'b1;
        if (i_req_valid) begin
          if (acc_err_c)                                 state_d = S_RESP;
          else if (acc_mem_c && i_req_we && (i_req_size == SZ_WORD)) state_d = S_MEM_WR;
          else if (acc_mem_c)                            state_d = S_MEM_RD;
          else                                           state_d = S_IO_REQ;
        end
      end
      S_MEM_RD: begin
        o_mem_addr = addr_q[7:2];
        state_d    = S_MEM_DATA;
      end
      S_MEM_DATA: begin
        o_mem_addr = addr_q[7:2];
        state_d    = we_q ? S_MEM_WR : S_RESP;
      end
      S_MEM_WR: begin
        o_mem_addr  = addr_q[7:2];
        o_mem_wren  = 1'b1;
        o_mem_wdata = wbuf_q;
        state_d     = S_RESP;
      end
      S_IO_REQ: begin
        o_io_req   = 1'b1;
        o_io_wren  = we_q;
        o_io_addr  = addr_q;
        o_io_bmask = bmask_c;
        o_io_wdata = wbuf_q;
        if (i_io_ack || timeout_c) state_d = S_RESP;
      end
      S_RESP: begin
        o_rsp_valid = 1'b1;
        o_rsp_rdata = rdata_q;
        o_rsp_err   = err_q;
        state_d     = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
    if (i_reset) begin
      o_req_ready = 1'b0;
      o_rsp_valid = 1'b0;
      o_rsp_rdata = '0;
      o_rsp_err   = 1'b0;
      o_mem_addr  = '0;
      o_mem_wren  = 1'b0;
      o_mem_wdata = '0;
      o_io_req    = 1'b0;
      o_io_wren   = 1'b0;
      o_io_addr   = '0;
      o_io_bmask  = '0;
      o_io_wdata  = '0;
    end
  end

  // Request capture, RMW merge, response data and IO timeout counter.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      addr_q  <= '0;
      size_q  <= '0;
      we_q    <= 1'b0;
      uns_q   <= 1'b0;
      wbuf_q  <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (i_req_valid) begin
            addr_q  <= i_req_addr[7:0];
            size_q  <= i_req_size;
            we_q    <= i_req_we;
            uns_q   <= i_req_unsigned;
            wbuf_q  <= replicate(i_req_wdata, i_req_size);
            rdata_q <= '0;
            err_q   <= acc_err_c;
            cnt_q   <= CNT_W'(1);
          end
        end
        S_MEM_DATA: begin
          if (we_q) wbuf_q  <= merge_lanes(wbuf_q, i_mem_rdata, bmask_c);
          else      rdata_q <= format_load(i_mem_rdata, addr_q[1:0], size_q, uns_q);
        end
        S_IO_REQ: begin
          if (i_io_ack) begin
            if (!we_q) rdata_q <= format_load(i_io_rdata, addr_q[1:0], size_q, uns_q);
          end else if (timeout_c) begin
            err_q <= 1'b1;
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_lsu_ctrl.sv
// Directed bench for lsu_ctrl with a small synchronous-read word memory model.
module tb_lsu_ctrl;

  localparam int unsigned TO = 255;

  logic        i_clk;
  logic        i_reset;
  logic        i_req_valid;
  logic        o_req_ready;
  logic        i_req_we;
  logic [11:0] i_req_addr;
  logic [1:0]  i_req_size;
  logic        i_req_unsigned;
  logic [31:0] i_req_wdata;
  logic        o_rsp_valid;
  logic [31:0] o_rsp_rdata;
  logic        o_rsp_err;
  logic [5:0]  o_mem_addr;
  logic        o_mem_wren;
  logic [31:0] o_mem_wdata;
  logic [31:0] i_mem_rdata;
  logic        o_io_req;
  logic        o_io_wren;
  logic [7:0]  o_io_addr;
  logic [3:0]  o_io_bmask;
  logic [31:0] o_io_wdata;
  logic        i_io_ack;
  logic [31:0] i_io_rdata;

  int checks = 0;
  int errors = 0;

  logic [31:0] mem [64];

  lsu_ctrl #(.IO_TIMEOUT(TO)) dut (
    .i_clk(i_clk), .i_reset(i_reset),
    .i_req_valid(i_req_valid), .o_req_ready(o_req_ready),
    .i_req_we(i_req_we), .i_req_addr(i_req_addr), .i_req_size(i_req_size),
    .i_req_unsigned(i_req_unsigned), .i_req_wdata(i_req_wdata),
    .o_rsp_valid(o_rsp_valid), .o_rsp_rdata(o_rsp_rdata), .o_rsp_err(o_rsp_err),
    .o_mem_addr(o_mem_addr), .o_mem_wren(o_mem_wren), .o_mem_wdata(o_mem_wdata),
    .i_mem_rdata(i_mem_rdata),
    .o_io_req(o_io_req), .o_io_wren(o_io_wren), .o_io_addr(o_io_addr),
    .o_io_bmask(o_io_bmask), .o_io_wdata(o_io_wdata),
    .i_io_ack(i_io_ack), .i_io_rdata(i_io_rdata)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  // Word memory: one-cycle synchronous read, write on strobe.
  always @(posedge i_clk) begin
    if (o_mem_wren) mem[o_mem_addr] <= o_mem_wdata;
    i_mem_rdata <= mem[o_mem_addr];
  end

  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // Present one request for a single accept cycle; returns in cycle 1.
  task automatic send(input logic we, input logic [11:0] addr, input logic [1:0] size,
                      input logic uns, input logic [31:0] wdata);
    i_req_valid    = 1'b1;
    i_req_we       = we;
    i_req_addr     = addr;
    i_req_size     = size;
    i_req_unsigned = uns;
    i_req_wdata    = wdata;
    tick();
    i_req_valid    = 1'b0;
  endtask

  initial begin
    i_reset = 1'b1;
    i_req_valid = 1'b0; i_req_we = 1'b0; i_req_addr = '0; i_req_size = '0;
    i_req_unsigned = 1'b0; i_req_wdata = '0; i_io_ack = 1'b0; i_io_rdata = '0;
    tick(); tick();

    chk("reset_ready", 32'(o_req_ready), 32'd0);
    chk("reset_rsp_valid", 32'(o_rsp_valid), 32'd0);
    chk("reset_mem_wren", 32'(o_mem_wren), 32'd0);
    chk("reset_io_req", 32'(o_io_req), 32'd0);
    i_reset = 1'b0;
    tick();
    chk("post_reset_ready", 32'(o_req_ready), 32'd1);

    // Word store: write in cycle 1, response in cycle 2.
    send(1'b1, 12'h104, 2'b10, 1'b0, 32'hDEADBEEF);
    chk("wst_c1_wren", 32'(o_mem_wren), 32'd1);
    chk("wst_c1_addr", 32'(o_mem_addr), 32'h01);
    chk("wst_c1_wdata", o_mem_wdata, 32'hDEADBEEF);
    chk("wst_c1_ready", 32'(o_req_ready), 32'd0);
    tick();
    chk("wst_c2_rsp", 32'(o_rsp_valid), 32'd1);
    chk("wst_c2_err", 32'(o_rsp_err), 32'd0);
    chk("wst_c2_wren", 32'(o_mem_wren), 32'd0);
    tick();
    chk("wst_c3_ready", 32'(o_req_ready), 32'd1);

    // Byte store RMW into 0x11223344.
    send(1'b1, 12'h104, 2'b10, 1'b0, 32'h11223344);
    tick(); tick();
    send(1'b1, 12'h105, 2'b00, 1'b0, 32'h000000AA);
    chk("bst_c1_wren", 32'(o_mem_wren), 32'd0);
    tick();
    chk("bst_c2_wren", 32'(o_mem_wren), 32'd0);
    tick();
    chk("bst_c3_wren", 32'(o_mem_wren), 32'd1);
    chk("bst_c3_wdata", o_mem_wdata, 32'h1122AA44);
    chk("bst_c3_rsp", 32'(o_rsp_valid), 32'd0);
    tick();
    chk("bst_c4_rsp", 32'(o_rsp_valid), 32'd1);
    chk("bst_c4_err", 32'(o_rsp_err), 32'd0);
    tick();

    // Word load reads back merged word at cycle 3.
    send(1'b0, 12'h104, 2'b10, 1'b0, 32'h0);
    tick();
    chk("wld_c2_rsp", 32'(o_rsp_valid), 32'd0);
    tick();
    chk("wld_c3_rsp", 32'(o_rsp_valid), 32'd1);
    chk("wld_c3_rdata", o_rsp_rdata, 32'h1122AA44);
    tick();

    // Sign/zero extension of sub-word loads.
    send(1'b1, 12'h104, 2'b10, 1'b0, 32'h80000000);
    tick(); tick();
    send(1'b0, 12'h107, 2'b00, 1'b0, 32'h0);
    tick(); tick();
    chk("lb_s_rsp", 32'(o_rsp_valid), 32'd1);
    chk("lb_s_rdata", o_rsp_rdata, 32'hFFFFFF80);
    tick();
    send(1'b0, 12'h107, 2'b00, 1'b1, 32'h0);
    tick(); tick();
    chk("lb_u_rdata", o_rsp_rdata, 32'h00000080);
    tick();
    send(1'b0, 12'h106, 2'b01, 1'b0, 32'h0);
    tick(); tick();
    chk("lh_s_rdata", o_rsp_rdata, 32'hFFFF8000);
    tick();

    // Error responses in cycle 1 with no strobes.
    send(1'b1, 12'h101, 2'b01, 1'b0, 32'h1234);
    chk("mis_rsp", 32'(o_rsp_valid), 32'd1);
    chk("mis_err", 32'(o_rsp_err), 32'd1);
    chk("mis_rdata", o_rsp_rdata, 32'h0);
    chk("mis_wren", 32'(o_mem_wren), 32'd0);
    chk("mis_ioreq", 32'(o_io_req), 32'd0);
    tick();
    send(1'b0, 12'h300, 2'b10, 1'b0, 32'h0);
    chk("unm_rsp", 32'(o_rsp_valid), 32'd1);
    chk("unm_err", 32'(o_rsp_err), 32'd1);
    chk("unm_ioreq", 32'(o_io_req), 32'd0);
    tick();
    send(1'b0, 12'h104, 2'b11, 1'b0, 32'h0);
    chk("ill_size_err", 32'(o_rsp_err), 32'd1);
    tick();
    send(1'b0, 12'hC04, 2'b10, 1'b0, 32'h0);
    chk("hi_addr_err", 32'(o_rsp_err), 32'd1);
    tick();

    // IO half store, ack in cycle 3, response in cycle 4.
    send(1'b1, 12'h202, 2'b01, 1'b0, 32'h0000BEEF);
    chk("ioh_req", 32'(o_io_req), 32'd1);
    chk("ioh_wren", 32'(o_io_wren), 32'd1);
    chk("ioh_addr", 32'(o_io_addr), 32'h02);
    chk("ioh_bmask", 32'(o_io_bmask), 32'hC);
    chk("ioh_wdata", o_io_wdata, 32'hBEEFBEEF);
    chk("ioh_memwren", 32'(o_mem_wren), 32'd0);
    tick();
    chk("ioh_c2_req", 32'(o_io_req), 32'd1);
    tick();
    chk("ioh_c3_req", 32'(o_io_req), 32'd1);
    i_io_ack = 1'b1;
    tick();
    i_io_ack = 1'b0;
    chk("ioh_c4_rsp", 32'(o_rsp_valid), 32'd1);
    chk("ioh_c4_err", 32'(o_rsp_err), 32'd0);
    chk("ioh_c4_req", 32'(o_io_req), 32'd0);
    tick();

    // IO byte load, signed, ack in cycle 1.
    send(1'b0, 12'h203, 2'b00, 1'b0, 32'h0);
    chk("iob_bmask", 32'(o_io_bmask), 32'h8);
    chk("iob_wren", 32'(o_io_wren), 32'd0);
    i_io_ack = 1'b1; i_io_rdata = 32'h80123456;
    tick();
    i_io_ack = 1'b0;
    chk("iob_rsp", 32'(o_rsp_valid), 32'd1);
    chk("iob_rdata", o_rsp_rdata, 32'hFFFFFF80);
    tick();

    // Stray ack in IDLE is ignored.
    i_io_ack = 1'b1;
    tick();
    i_io_ack = 1'b0;
    chk("stray_ack_rsp", 32'(o_rsp_valid), 32'd0);
    chk("stray_ack_ready", 32'(o_req_ready), 32'd1);

    // IO load timeout: req high for TO cycles, error response after.
    send(1'b0, 12'h210, 2'b10, 1'b0, 32'h0);
    for (int c = 1; c <= int'(TO); c++) begin
      chk("to_req_held", 32'(o_io_req), 32'd1);
      chk("to_no_rsp", 32'(o_rsp_valid), 32'd0);
      tick();
    end
    chk("to_rsp", 32'(o_rsp_valid), 32'd1);
    chk("to_err", 32'(o_rsp_err), 32'd1);
    chk("to_rdata", o_rsp_rdata, 32'h0);
    chk("to_req_low", 32'(o_io_req), 32'd0);
    tick();

    // Reset during MEM_DATA of a byte store drops the access.
    send(1'b1, 12'h108, 2'b10, 1'b0, 32'h11223344);
    tick(); tick();
    send(1'b1, 12'h108, 2'b00, 1'b0, 32'h00000055);
    tick();
    i_reset = 1'b1;
    #1;
    chk("rst_mid_ready", 32'(o_req_ready), 32'd0);
    chk("rst_mid_wren", 32'(o_mem_wren), 32'd0);
    tick();
    chk("rst_c3_wren", 32'(o_mem_wren), 32'd0);
    chk("rst_c3_rsp", 32'(o_rsp_valid), 32'd0);
    tick();
    i_reset = 1'b0;
    #1;
    chk("rst_rel_ready", 32'(o_req_ready), 32'd1);
    chk("rst_rel_wren", 32'(o_mem_wren), 32'd0);
    chk("rst_rel_rsp", 32'(o_rsp_valid), 32'd0);
    tick();
    chk("rst_after_wren", 32'(o_mem_wren), 32'd0);
    chk("rst_after_rsp", 32'(o_rsp_valid), 32'd0);
    send(1'b0, 12'h108, 2'b10, 1'b0, 32'h0);
    tick(); tick();
    chk("rst_word_intact", o_rsp_rdata, 32'h11223344);
    tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/lsu_ctrl.md
Name:
lsu_ctrl

Overview:
- Load-store sequencer between the core's memory stage and the data-memory and IO regions.
- Region decode on addr[9:8]: 01 is data memory (0x100–0x1FF), 10 is IO (0x200–0x2FF).
- Data memory is word-wide with a 1-cycle synchronous read and no byte enables, so byte and half stores to it are done as read-modify-write.
- IO accesses use a req/ack handshake with byte mask, guarded by a timeout.

Parameters:
- IO_TIMEOUT, 255: maximum cycles `o_io_req` stays high without `i_io_ack` before the access is aborted with an error (range 1..255, 8-bit counter).

Ports:
- i_clk  in  1  clock; all state changes on the rising edge
- i_reset  in  1  synchronous reset, active-high
- i_req_valid  in  1  core request valid
- o_req_ready  out  1  high only in IDLE; a request is accepted when valid and ready are both high
- i_req_we  in  1  1 = store, 0 = load
- i_req_addr  in  12  byte address
- i_req_size  in  2  00 = byte, 01 = half, 10 = word, 11 = illegal
- i_req_unsigned  in  1  load zero-extend (1) or sign-extend (0)
- i_req_wdata  in  32  store data, right-aligned
- o_rsp_valid  out  1  one-cycle response strobe; no backpressure
- o_rsp_rdata  out  32  formatted load data; 0 for stores and errors
- o_rsp_err  out  1  misaligned, illegal size, unmapped, or IO timeout
- o_mem_addr  out  6  word index, equal to addr[7:2]
- o_mem_wren  out  1  data-memory write strobe
- o_mem_wdata  out  32  full word to write
- i_mem_rdata  in  32  word read data, valid the cycle after o_mem_addr is presented
- o_io_req  out  1  IO access request, held until ack or timeout
- o_io_wren  out  1  IO store qualifier, valid while o_io_req is high
- o_io_addr  out  8  IO byte address, equal to addr[7:0]
- o_io_bmask  out  4  byte lanes written
- o_io_wdata  out  32  lane-aligned store data
- i_io_ack  in  1  IO completion, single cycle
- i_io_rdata  in  32  IO word read data, valid with ack

Behaviour:
- Reset:
  - On a clock edge with `i_reset` high, the state goes to IDLE and all registers clear.
  - While `i_reset` is high, every output is 0, including `o_req_ready`.
- Accept:
  - In IDLE with `i_req_valid` high, latch addr, size, we, unsigned and wdata; `o_req_ready` drops the next cycle.
- Error checks at accept:
  - size 11 is an error.
  - half with addr[0]=1 is an error.
  - word with addr[1:0]≠0 is an error.
  - addr[11:10]≠0 is an error.
  - addr[9:8] of 00 or 11 is an error.
  - On any error: go to RESP with err=1; no memory or IO strobe is ever issued.
- States and transitions:
  - IDLE:
    - mem word store → MEM_WR
    - mem load or mem sub-word store → MEM_RD
    - IO access → IO_REQ
    - error → RESP
  - MEM_RD:
    - drive `o_mem_addr` → MEM_DATA
  - MEM_DATA:
    - sample `i_mem_rdata`.
    - load: format the data → RESP.
    - sub-word store: merge new lanes into the sampled word → MEM_WR.
  - MEM_WR:
    - `o_mem_wren`=1 for exactly one cycle with `o_mem_addr` and `o_mem_wdata` → RESP.
  - IO_REQ:
    - hold `o_io_req`=1 with stable addr, wren, bmask and wdata.
    - `i_io_ack` → sample rdata → RESP, err=0.
    - timeout counter reaches IO_TIMEOUT → RESP, err=1, rdata=0.
    - If ack arrives in the same cycle as timeout, ack wins.
  - RESP:
    - `o_rsp_valid`=1 for one cycle → IDLE.
- Latency from the accept cycle (cycle 0) to `o_rsp_valid`:
  - Error response: cycle 1.
  - Mem word store: cycle 2.
  - Mem load: cycle 3.
  - Mem sub-word store: cycle 4.
  - IO access: ack cycle + 1.
- Lane mapping:
  - Byte lane = addr[1:0]; half lane = addr[1].
  - bmask is 0001<<addr[1:0] for a byte, 0011<<addr[1:0] for a half, 1111 for a word.
  - Store data is replicated across lanes (byte ×4, half ×2).
- Merge (sub-word mem store): lane k of the written word = new data if bmask[k], else the old word's lane k.
- Load format:
  - Select the lane by addr[1:0], then extend to 32 bits.
  - Sign-extend from bit 7 (byte) or bit 15 (half) when `i_req_unsigned`=0; zero-extend otherwise.
  - Word loads pass through unchanged.
- Strobe rules:
  - `o_mem_wren` and `o_io_req` are never high simultaneously.
  - `i_io_ack` outside IO_REQ is ignored.
- Reset mid-operation:
  - The access is dropped with no write and no response, including reset during MEM_WR; the strobe is gated by `i_reset`.
  - `o_req_ready`=1 on the first cycle after reset deasserts.

Test Plan:
- Word store 0xDEADBEEF to 0x104 → cycle 1: `o_mem_wren`=1, `o_mem_addr`=0x01, `o_mem_wdata`=0xDEADBEEF; cycle 2: `o_rsp_valid`=1, err=0.
- Memory word 0x01 holds 0x11223344; byte store 0xAA to 0x105 → cycle 3 write of 0x1122AA44; rsp at cycle 4.
- Memory word 0x01 holds 0x80000000; byte load 0x107 signed → rdata 0xFFFFFF80; unsigned → 0x00000080; cycle 3 response.
- Misaligned and unmapped accesses:
  - Half store to 0x101 → cycle 1: err=1, rdata=0, no `o_mem_wren` or `o_io_req`.
  - Load from 0x300 → same response.
- IO half store 0xBEEF to 0x202 with ack after 3 cycles → bmask=1100, wdata=0xBEEFBEEF, rsp err=0.
- IO load with ack never asserted → rsp err=1 exactly IO_TIMEOUT cycles after `o_io_req` rises.
- Reset asserted during MEM_DATA of a byte store → no `o_mem_wren`, no rsp, ready=1 the cycle after reset drops.
